// File: rtl/systema_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the systema output PIO.
// A write happens on the rising clk edge where chipselect=1 and write_n=0; reads are combinational, zero wait states, no backpressure.
interface systema_pio_out_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/systema_pio_out_pulse.sv
// Output PIO with atomic set/clear and a hardware pulse timer.
// Define SYSTEMA_PIO_PULSE_EN to build the pulse timer (PULSE_LEN/PULSE/COUNT and pulse_done).
module systema_pio_out_pulse #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    systema_pio_out_pulse_if.slave    bus,
    output logic [DATA_WIDTH-1:0]     out_port,
    output logic                      pulse_done
);
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_LEN    = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLEAR  = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_COUNT  = 3'd5;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  unused_writedata;

    assign wr_en            = bus.chipselect & ~bus.write_n;
    assign wd_data          = bus.writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^bus.writedata;
    assign out_port         = data_q;

`ifdef SYSTEMA_PIO_PULSE_EN
    logic [CNT_WIDTH-1:0]  wd_cnt;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic                  done_q, done_d;
    logic                  expire;

    assign wd_cnt     = bus.writedata[CNT_WIDTH-1:0];
    assign expire     = (count_q == CNT_WIDTH'(1));
    assign pulse_done = done_q;

    // Expiry is applied first so a same-edge write overrides the bits it touches.
    always_comb begin
        data_d  = data_q;
        len_d   = len_q;
        mask_d  = mask_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (count_q != '0) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
        if (expire) begin
            data_d = data_q & ~mask_q;
            mask_d = '0;
            done_d = 1'b1;
        end
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA: begin
                    data_d  = wd_data;
                    mask_d  = '0;
                    count_d = '0;
                end
                ADDR_LEN:   len_d  = wd_cnt;
                ADDR_SET:   data_d = data_d | wd_data;
                ADDR_CLEAR: begin
                    data_d = data_d & ~wd_data;
                    mask_d = mask_d & ~wd_data;
                    if (mask_d == '0) begin
                        count_d = '0;
                    end
                end
                ADDR_PULSE: begin
                    if ((len_q != '0) && (wd_data != '0)) begin
                        data_d  = data_d | wd_data;
                        mask_d  = mask_d | wd_data;
                        count_d = len_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            len_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:  bus.readdata[DATA_WIDTH-1:0] = data_q;
            ADDR_LEN:   bus.readdata[CNT_WIDTH-1:0]  = len_q;
            ADDR_PULSE: bus.readdata[DATA_WIDTH-1:0] = mask_q;
            ADDR_COUNT: bus.readdata[CNT_WIDTH-1:0]  = count_q;
            default: ;
        endcase
    end
`else
    assign pulse_done = 1'b0;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:  data_d = wd_data;
                ADDR_SET:   data_d = data_q | wd_data;
                ADDR_CLEAR: data_d = data_q & ~wd_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.address == ADDR_DATA) begin
            bus.readdata[DATA_WIDTH-1:0] = data_q;
        end
    end
`endif
endmodule

// File: tb/tb_systema_pio_out_pulse.sv
// Bench for systema_pio_out_pulse: directed test-plan scenarios then random bus traffic against a timeline model.
module tb_systema_pio_out_pulse;
`ifdef SYSTEMA_PIO_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    localparam logic [7:0] RV = 8'hA5;

    logic       clk;
    logic       reset;
    logic [7:0] out_port;
    logic       pulse_done;

    systema_pio_out_pulse_if bus();

    systema_pio_out_pulse #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16),
        .RESET_VALUE(RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .out_port  (out_port),
        .pulse_done(pulse_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pulse is an absolute expiry edge index, not a counter.
    logic [7:0]  m_data;
    logic [15:0] m_len;
    logic [7:0]  m_mask;
    bit          m_active;
    int          m_expire;
    bit          m_done;
    int          edge_n;
    logic [8:0]  exp_q[$];

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd1: return PE ? {16'd0, m_len} : 32'd0;
            3'd4: return PE ? {24'd0, m_mask} : 32'd0;
            3'd5: return (PE && m_active) ? 32'(m_expire - edge_n) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [2:0] a, input logic cs,
                              input logic wn, input logic [31:0] wd);
        edge_n++;
        m_done = 1'b0;
        if (r) begin
            m_data   = RV;
            m_len    = '0;
            m_mask   = '0;
            m_active = 1'b0;
        end else begin
            if (m_active && edge_n == m_expire) begin
                m_data   = m_data & ~m_mask;
                m_mask   = '0;
                m_active = 1'b0;
                m_done   = 1'b1;
            end
            if (cs && !wn) begin
                case (a)
                    3'd0: begin
                        m_data   = wd[7:0];
                        m_mask   = '0;
                        m_active = 1'b0;
                    end
                    3'd1: if (PE) m_len = wd[15:0];
                    3'd2: m_data = m_data | wd[7:0];
                    3'd3: begin
                        m_data = m_data & ~wd[7:0];
                        m_mask = m_mask & ~wd[7:0];
                        if (m_mask == '0) m_active = 1'b0;
                    end
                    3'd4: begin
                        if (PE && m_len != '0 && wd[7:0] != '0) begin
                            m_data   = m_data | wd[7:0];
                            m_mask   = m_mask | wd[7:0];
                            m_active = 1'b1;
                            m_expire = edge_n + int'(m_len);
                        end
                    end
                    default: ;
                endcase
            end
        end
        exp_q.push_back({m_done, m_data});
    endtask

    // driver tasks
    task automatic drive(input logic r, input logic [2:0] a, input logic cs,
                         input logic wn, input logic [31:0] wd);
        logic [8:0] e;
        @(negedge clk);
        reset          = r;
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        #1;
        check("readdata", bus.readdata, model_read(a));
        @(posedge clk);
        model_edge(r, a, cs, wn, wd);
        #1;
        e = exp_q.pop_front();
        check("out_port", {24'd0, out_port}, {24'd0, e[7:0]});
        check("pulse_done", {31'd0, pulse_done}, {31'd0, e[8]});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        drive(1'b0, a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b0, a, 1'b1, 1'b1, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rwd;
        m_data = RV; m_len = '0; m_mask = '0; m_active = 1'b0;
        m_expire = 0; m_done = 1'b0; edge_n = 0;
        reset = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        // reset, including a write that reset must override
        drive(1'b1, 3'd0, 1'b0, 1'b1, 32'd0);
        drive(1'b1, 3'd0, 1'b1, 1'b0, 32'h3C);
        check("rst_hold", {24'd0, out_port}, 32'h0000_00A5);
        rd(3'd0);
        check("rst_readdata", bus.readdata, 32'h0000_00A5);

        // set / clear
        wr(3'd0, 32'h0F);
        wr(3'd2, 32'hF0);
        check("outset", {24'd0, out_port}, 32'h0000_00FF);
        wr(3'd3, 32'h81);
        check("outclear", {24'd0, out_port}, 32'h0000_007E);
        rd(3'd2);
        rd(3'd3);

        // basic pulse, COUNT readback 5..0
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h00);
        wr(3'd4, 32'h03);
        for (int i = 0; i < 5; i++) rd(3'd5);
        if (PE) check("pulse_expiry_done", {31'd0, pulse_done}, 32'd1);
        rd(3'd5);
        idle(2);

        // retrigger
        wr(3'd1, 32'd4);
        wr(3'd4, 32'h01);
        idle(1);
        wr(3'd4, 32'h02);
        idle(5);

        // cancel by DATA write
        wr(3'd1, 32'd10);
        wr(3'd4, 32'h01);
        idle(2);
        wr(3'd0, 32'h80);
        rd(3'd5);
        idle(12);

        // zero length pulse is ignored
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h00);
        wr(3'd4, 32'hFF);
        check("zero_len_pulse", {24'd0, out_port}, 32'd0);

        // pulse write on the expiry edge
        wr(3'd1, 32'd3);
        wr(3'd4, 32'h01);
        idle(2);
        wr(3'd4, 32'h04);
        rd(3'd5);
        idle(4);

        // OUTCLEAR removing the whole mask mid-pulse
        wr(3'd4, 32'h30);
        wr(3'd3, 32'h30);
        idle(4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rwd = $urandom;
            if (ra == 3'd1 && $urandom_range(0, 7) != 0) rwd = $urandom_range(0, 6);
            if ($urandom_range(0, 149) == 0) begin
                drive(1'b1, ra, 1'b1, 1'b0, rwd);
            end else begin
                drive(1'b0, ra, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rwd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
